// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: single-port data memory answering LSU requests with optional grant stall.
// Define LSU_MEM_RESP_RANGE_ERR_EN to flag out-of-range addresses as bus errors instead of wrapping.
module lsu_mem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int GNT_DELAY = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         data_req_i,
    input  logic [31:0]                  data_addr_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_wdata_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic [31:0]                  data_rdata_o,
    output logic                         data_err_o,
    input  logic                         bd_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_addr_i,
    input  logic [31:0]                  bd_wdata_i,
    output logic [31:0]                  bd_rdata_o,
    output logic                         proto_err_o
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic {IDLE, STALL} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic          gnt, proto_set, range_err, store, load;
    logic [AW-1:0] idx;
    logic [31:0]   mem [MEM_WORDS];
    logic          rvalid_q, proto_q;
    logic [31:0]   rdata_q;
    logic          unused_addr;

    assign idx = data_addr_i[AW+1:2];
    assign unused_addr = ^{data_addr_i[1:0], data_addr_i[31:AW+2]};

`ifdef LSU_MEM_RESP_RANGE_ERR_EN
    logic err_q;
    assign range_err  = |data_addr_i[31:AW+2];
    assign data_err_o = err_q & ~rst_i;
`else
    assign range_err  = 1'b0;
    assign data_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt       = 1'b0;
        proto_set = 1'b0;
        if (state == IDLE) begin
            if (data_req_i) begin
                if (GNT_DELAY == 0) begin
                    gnt = 1'b1;
                end else begin
                    state_nxt = STALL;
                    cnt_nxt   = 3'd1;
                end
            end
        end else if (!data_req_i) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
            proto_set = 1'b1;
        end else if (cnt == 3'(GNT_DELAY)) begin
            gnt       = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
        end else begin
            cnt_nxt = cnt + 3'd1;
        end
        if (rst_i) begin
            gnt       = 1'b0;
            proto_set = 1'b0;
        end
    end

    assign store = gnt & data_we_i & ~range_err;
    assign load  = gnt & ~data_we_i & ~range_err;

    // Lane writes come after the backdoor write so a granted store wins on its enabled lanes.
    always_ff @(posedge clk_i) begin
        if (bd_we_i) mem[bd_addr_i] <= bd_wdata_i;
        for (int b = 0; b < 4; b++) begin
            if (store && data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            proto_q  <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            if (gnt) rdata_q <= load ? mem[idx] : 32'd0;
            if (proto_set) proto_q <= 1'b1;
        end
    end

`ifdef LSU_MEM_RESP_RANGE_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else if (gnt) err_q <= range_err;
    end
`endif

    // Outputs are masked while reset is high so a response already in flight is dropped.
    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q & ~rst_i;
    assign data_rdata_o  = rst_i ? 32'd0 : rdata_q;
    assign proto_err_o   = proto_q & ~rst_i;
    assign bd_rdata_o    = mem[bd_addr_i];
endmodule
